// File: rtl/ex_div.sv
// ex_div: iterative restoring divider for DIV/DIVU/REM/REMU; `EX_DIV_FAST_PATH_EN enables single-cycle divide-by-zero/overflow results
module ex_div #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          cancel_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [DW-1:0] result_o,
    output logic [4:0]    rd_addr_o,
    output logic          reg_wen_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [DW-1:0] LAST = DW'(DW - 1);
    state_t state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, result_q, result_d;
    logic [4:0] rd_q, rd_d, rd_addr_q, rd_addr_d;
    logic rem_op_q, rem_op_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic sgn, a_neg, b_neg, dz_in, ge;
    logic [DW-1:0] a_mag, b_mag, rem_step, quot_step, fin_q, fin_r;
    logic [DW:0] tmp, sub;
`ifdef EX_DIV_FAST_PATH_EN
    logic ovf_in;
`endif
    // operand magnitudes and one restoring shift-subtract step
    always_comb begin
        sgn = !op_i[0];
        a_neg = sgn & dividend_i[DW-1];
        b_neg = sgn & divisor_i[DW-1];
        a_mag = a_neg ? -dividend_i : dividend_i;
        b_mag = b_neg ? -divisor_i : divisor_i;
        dz_in = divisor_i == '0;
`ifdef EX_DIV_FAST_PATH_EN
        ovf_in = sgn && dividend_i == {1'b1, {(DW-1){1'b0}}} && divisor_i == '1;
`endif
        tmp = {rem_q, quot_q[DW-1]};
        sub = tmp - {1'b0, dvs_q};
        ge = !sub[DW];
        rem_step = ge ? sub[DW-1:0] : tmp[DW-1:0];
        quot_step = {quot_q[DW-2:0], ge};
        fin_q = dz_q ? '1 : (qneg_q ? -quot_step : quot_step);
        fin_r = rneg_q ? -rem_step : rem_step;
    end
    // next-state: capture in IDLE, iterate in CALC, one-cycle DONE; cancel wins everywhere
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        quot_d = quot_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        result_d = result_q;
        rd_d = rd_q;
        rd_addr_d = rd_addr_q;
        rem_op_d = rem_op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        dz_d = dz_q;
        case (state_q)
            IDLE: if (start_i && !cancel_i) begin
                rem_op_d = op_i[1];
                rd_d = rd_addr_i;
                quot_d = a_mag;
                rem_d = '0;
                dvs_d = b_mag;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                dz_d = dz_in;
                cnt_d = '0;
                state_d = CALC;
`ifdef EX_DIV_FAST_PATH_EN
                if (dz_in || ovf_in) begin
                    state_d = DONE;
                    result_d = op_i[1] ? (dz_in ? dividend_i : '0) : (dz_in ? '1 : dividend_i);
                    rd_addr_d = rd_addr_i;
                end
`endif
            end
            CALC: if (cancel_i) state_d = IDLE;
            else begin
                quot_d = quot_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    result_d = rem_op_q ? fin_r : fin_q;
                    rd_addr_d = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            quot_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            result_q <= '0;
            rd_q <= '0;
            rd_addr_q <= '0;
            rem_op_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            quot_q <= quot_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            result_q <= result_d;
            rd_q <= rd_d;
            rd_addr_q <= rd_addr_d;
            rem_op_q <= rem_op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dz_q <= dz_d;
        end
    end
    assign busy_o = state_q != IDLE;
    assign ready_o = state_q == DONE;
    assign reg_wen_o = ready_o;
    assign result_o = result_q;
    assign rd_addr_o = rd_addr_q;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vector bench for ex_div (latency follows EX_DIV_FAST_PATH_EN)
module tb_ex_div;
    localparam int DW = 32;
`ifdef EX_DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start_i, cancel_i, busy_o, ready_o, reg_wen_o;
    logic [1:0] op_i;
    logic [DW-1:0] dividend_i, divisor_i, result_o;
    logic [4:0] rd_addr_i, rd_addr_o;
    int n_chk = 0;
    int n_fail = 0;

    ex_div #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
        .cancel_i(cancel_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          fast;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        rd_addr_i = rd;
    endtask

    task automatic wait_done(input logic [31:0] exp, input logic [4:0] rd, input bit fast, input string tag);
        int lat = 0;
        @(posedge clk);
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (ready_o) lat = k;
        end
        chk({tag, " latency"}, lat, (fast && FAST) ? 32'd1 : 32'(DW + 1));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " rd_addr"}, rd_addr_o, rd);
        chk({tag, " reg_wen"}, reg_wen_o, 1);
        chk({tag, " busy_done"}, busy_o, 1);
        @(negedge clk);
        chk({tag, " ready_one_cycle"}, ready_o, 0);
        chk({tag, " busy_idle"}, busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        v[0]  = '{2'b00, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
        v[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFF,  1'b0};
        v[2]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,          5'd2,  32'h7FFF_FFFF,  1'b0};
        v[3]  = '{2'b01, 32'd5,          32'd0,          5'd3,  32'hFFFF_FFFF,  1'b1};
        v[4]  = '{2'b10, 32'd5,          32'd0,          5'd4,  32'd5,          1'b1};
        v[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,  1'b1};
        v[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0,          1'b1};
        v[7]  = '{2'b00, 32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFF2,  1'b0};
        v[8]  = '{2'b11, 32'd100,        32'd7,          5'd9,  32'd2,          1'b0};
        v[9]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          5'd10, 32'hFFFF_FFFF,  1'b1};
        v[10] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          5'd11, 32'hFFFF_FFFB,  1'b1};
        v[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1'b0};
        v[12] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd13, 32'd1,          1'b0};
        v[13] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'hFFFF_FFFD,  1'b0};
        rst = 1'b1;
        start_i = 1'b1;
        cancel_i = 1'b0;
        op_i = 2'b00;
        dividend_i = 32'd9;
        divisor_i = 32'd3;
        rd_addr_i = 5'd1;
        repeat (3) @(negedge clk);
        chk("reset busy", busy_o, 0);
        chk("reset ready", ready_o, 0);
        chk("reset reg_wen", reg_wen_o, 0);
        chk("reset result", result_o, 0);
        chk("reset rd_addr", rd_addr_o, 0);
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("idle busy", busy_o, 0);
        for (int i = 0; i < 14; i++) begin
            go(v[i].op, v[i].a, v[i].b, v[i].rd);
            wait_done(v[i].exp, v[i].rd, v[i].fast, $sformatf("vec%0d", i));
        end
        // start pulsed mid-CALC must be ignored
        go(2'b00, 32'd100, 32'd7, 5'd5);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (ready_o) lat = k;
            if (k == 5) go(2'b01, 32'd1000, 32'd10, 5'd9);
        end
        chk("ignore latency", lat, 32'(DW + 1));
        chk("ignore result", result_o, 32'd14);
        chk("ignore rd_addr", rd_addr_o, 5'd5);
        @(negedge clk);
        // cancel at N+10, restart at N+11
        go(2'b00, 32'd100, 32'd7, 5'd5);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (ready_o) seen = 1'b1;
            if (k == 10) cancel_i = 1'b1;
        end
        @(negedge clk);
        cancel_i = 1'b0;
        chk("cancel busy", busy_o, 0);
        chk("cancel ready", ready_o, 0);
        chk("cancel no_strobe", seen, 0);
        go(2'b01, 32'd50, 32'd3, 5'd7);
        wait_done(32'd16, 5'd7, 1'b0, "after_cancel");
        // reset at N+20 during CALC
        go(2'b11, 32'd100, 32'd7, 5'd3);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (ready_o) seen = 1'b1;
            if (k == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy_o, 0);
        chk("midrst ready", ready_o, 0);
        chk("midrst reg_wen", reg_wen_o, 0);
        chk("midrst result", result_o, 0);
        chk("midrst rd_addr", rd_addr_o, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        chk("midrst no_strobe", seen, 0);
        go(2'b00, 32'd100, 32'd7, 5'd5);
        wait_done(32'd14, 5'd5, 1'b0, "after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter DW, default 32: operand and result width (equal to the id_ex op1_o/op2_o width).
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start_i  input  1: request from EX when the inst_o held in id_ex decodes to DIV/DIVU/REM/REMU.
REQ-005 SHALL have port op_i  input  2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-006 SHALL have port dividend_i  input  DW: op1_o from id_ex.
REQ-007 SHALL have port divisor_i  input  DW: op2_o from id_ex.
REQ-008 SHALL have port rd_addr_i  input  5: destination register, captured with the request.
REQ-009 SHALL have port cancel_i  input  1: pipeline flush (taken jump/branch); aborts any operation in progress.
REQ-010 SHALL have port busy_o  output  1: operation in flight; EX uses it to hold if_id/id_ex.
REQ-011 SHALL have port ready_o  output  1: one-cycle strobe; result_o/rd_addr_o valid.
REQ-012 SHALL have port result_o  output  DW: quotient or remainder per op_i.
REQ-013 SHALL have port rd_addr_o  output  5: captured destination register.
REQ-014 SHALL have port reg_wen_o  output  1: equals ready_o; write-enable to the register file.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; IDLE is entered on reset.
REQ-016 SHALL, in IDLE with start_i=1 and cancel_i=0 at edge N, capture op_i, rd_addr_i, operand magnitudes and result signs, then enter CALC.
REQ-017 SHALL ignore start_i outside IDLE; operands are not re-sampled mid-operation.
REQ-018 SHALL perform one restoring shift-subtract step per CALC cycle, using a DW-bit iteration counter, for exactly DW cycles, then enter DONE.
REQ-019 SHALL, for signed ops, divide absolute values; quotient is negated iff the operand signs differ; remainder takes the sign of the dividend.
REQ-020 SHALL, for divisor zero, return quotient all ones and remainder equal to the dividend, for both signed and unsigned ops.
REQ-021 SHALL, for DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-022 SHALL assert ready_o and reg_wen_o for exactly the single DONE cycle (cycle N+DW+1 after the start edge N), then return to IDLE.
REQ-023 SHALL assert busy_o in CALC and DONE and deassert it in IDLE.
REQ-024 SHALL hold result_o and rd_addr_o registered from DONE until the next DONE; they are don't-care-free (stable), not zeroed.
REQ-025 SHALL, on cancel_i=1 in any state, go to IDLE at the next edge with ready_o=0 (cancel has priority over DONE completion and over start_i).
REQ-026 SHALL accept a new start_i in the first IDLE cycle after DONE (back-to-back throughput DW+2 cycles).

Reset
REQ-027 SHALL, with rst=1 at an edge, set state=IDLE, busy_o=0, ready_o=0, reg_wen_o=0, result_o=0, rd_addr_o=0 and counter=0; rst overrides start_i and cancel_i.
REQ-028 SHALL, when reset occurs mid-CALC, discard the operation without producing a ready_o strobe.

Configuration
REQ-029 SHALL provide the macro EX_DIV_FAST_PATH_EN.
REQ-030 SHALL, when EX_DIV_FAST_PATH_EN is defined, route divisor-zero and signed-overflow cases from IDLE directly to DONE, giving ready_o at N+1.
REQ-031 SHALL, when EX_DIV_FAST_PATH_EN is undefined, run all cases through the full DW-cycle CALC with identical results and ready_o at N+DW+1.

Verification
REQ-032 SHALL cover: DIV 100/7, rd=5 -> ready_o at N+33, result 14, rd_addr_o 5, reg_wen_o 1 for one cycle.
REQ-033 SHALL cover: REM -7/2 -> result 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-034 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; ready_o at N+1 with the macro defined, N+33 without.
REQ-035 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-036 SHALL cover: cancel_i at cycle N+10 -> busy_o=0 at N+11 and no ready_o; new start at N+11 completes normally.
REQ-037 SHALL cover: rst at N+20 during CALC -> all outputs 0 next cycle, no ready_o; start_i pulsed in CALC is ignored.
